// File: rtl/countdown_bcd_display.sv
// Countdown game timer held as a BCD digit chain, with a multiplexed 7-segment driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above DP_POS.
module countdown_bcd_display #(
    parameter int          NUM_DIGITS = 8,
    parameter int          TICK_DIV   = 5000,
    parameter logic [31:0] START_BCD  = 32'h0018_0000,
    parameter int          PENALTY    = 10,
    parameter int          SCAN_BITS  = 6,
    parameter int          DP_POS     = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    load,
    input  logic                    miss,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] time_bcd,
    output logic                    running,
    output logic                    expired,
    output logic                    expire_pulse
);

    localparam int              TW        = 4 * NUM_DIGITS;
    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   RELOAD    = START_BCD[TW-1:0];
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [8:0]      PEN9      = 9'(PENALTY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    state_t                 state, state_next;
    logic [TW-1:0]          time_next, time_dec;
    logic [PW-1:0]          presc, presc_next;
    logic [7:0]             pend, pend_next;
    logic [8:0]             pend_sum;
    logic [SCAN_BITS-1:0]   refresh;
    logic                   pulse_next;
    logic                   is_zero, tick, drain, dec_en, miss_ok, borrow;

    assign is_zero = (time_bcd == '0);
    assign tick    = (state == S_RUN) && (presc == TICK_LAST);
    // A tick takes the single decrement slot; penalty steps wait for a free cycle.
    assign drain   = (state == S_RUN) && !tick && (pend != 8'd0) && !is_zero;
    assign dec_en  = (state == S_RUN) && !is_zero && (tick || (pend != 8'd0));
    assign miss_ok = miss && ((state == S_RUN) || (state == S_PAUSE));

    assign running = (state == S_RUN);
    assign expired = (state == S_EXPIRED);

    // Ripple-borrow BCD decrement: zero digits become 9 until a nonzero digit absorbs it.
    always_comb begin
        time_dec = time_bcd;
        borrow   = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (borrow) begin
                if (time_bcd[4*d +: 4] == 4'd0) begin
                    time_dec[4*d +: 4] = 4'd9;
                end else begin
                    time_dec[4*d +: 4] = time_bcd[4*d +: 4] - 4'd1;
                    borrow             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        time_next  = time_bcd;
        presc_next = presc;
        pulse_next = 1'b0;
        pend_sum   = {1'b0, pend} + (miss_ok ? PEN9 : 9'd0) - {8'd0, drain};
        pend_next  = pend_sum[8] ? 8'hFF : pend_sum[7:0];

        case (state)
            S_IDLE: begin
                presc_next = '0;
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                presc_next = tick ? '0 : presc + PW'(1);
                if (is_zero) begin
                    state_next = S_EXPIRED;
                    pulse_next = 1'b1;
                    pend_next  = '0;
                end else if (pause) begin
                    state_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (start) state_next = S_RUN;
            end
            S_EXPIRED: begin
                presc_next = '0;
            end
            default: state_next = S_IDLE;
        endcase

        if (dec_en) time_next = time_dec;

        if (load) begin
            state_next = S_IDLE;
            time_next  = RELOAD;
            presc_next = '0;
            pend_next  = '0;
            pulse_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            time_bcd     <= RELOAD;
            presc        <= '0;
            pend         <= '0;
            refresh      <= '0;
            expire_pulse <= 1'b0;
        end else begin
            state        <= state_next;
            time_bcd     <= time_next;
            presc        <= presc_next;
            pend         <= pend_next;
            refresh      <= refresh + SCAN_BITS'(1);
            expire_pulse <= pulse_next;
        end
    end

    // ---------------- display multiplexer ----------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    logic [2:0]            idx;
    logic [3:0]            digit;
    logic                  slot_valid;
    logic [NUM_DIGITS-1:0] blank;

    assign idx        = refresh[SCAN_BITS-1 -: 3];
    assign slot_valid = (int'(idx) < NUM_DIGITS);

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_up;

    // zero_up[d]: digit d and every digit above it are zero.
    always_comb begin
        zero_up                 = '0;
        blank                   = '0;
        zero_up[NUM_DIGITS-1]   = (time_bcd[TW-1 -: 4] == 4'd0);
        for (int d = NUM_DIGITS - 2; d >= 0; d--) begin
            zero_up[d] = zero_up[d+1] && (time_bcd[4*d +: 4] == 4'd0);
        end
        for (int d = 1; d < NUM_DIGITS; d++) begin
            if (d > DP_POS) blank[d] = zero_up[d];
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        digit = 4'd0;
        an    = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx == 3'(d)) begin
                digit = time_bcd[4*d +: 4];
                an[d] = blank[d];
            end
        end
        seg = slot_valid ? seg_decode(digit) : 7'b1111111;
        dp  = (int'(idx) == DP_POS);
    end

endmodule

// File: tb/tb_countdown_bcd_display.sv
// Directed bench for countdown_bcd_display: cycle table for the controller, hand sequences
// for reset, display scan and asynchronous reset.
module tb_countdown_bcd_display;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, pause = 1'b0, load = 1'b0, miss = 1'b0;

    logic [6:0]  seg_m, seg_a, seg_b, seg_c;
    logic        dp_m, dp_a, dp_b, dp_c;
    logic [3:0]  an_m, an_a, an_b, an_c;
    logic [15:0] t_m, t_a, t_b, t_c;
    logic        r_m, r_a, r_b, r_c;
    logic        e_m, e_a, e_b, e_c;
    logic        p_m, p_a, p_b, p_c;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    countdown_bcd_display #(.NUM_DIGITS(4), .TICK_DIV(4), .START_BCD(32'h0000_0050),
        .PENALTY(10), .SCAN_BITS(3), .DP_POS(1)) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .load(load), .miss(miss),
        .seg(seg_m), .dp(dp_m), .an(an_m), .time_bcd(t_m), .running(r_m), .expired(e_m),
        .expire_pulse(p_m));

    countdown_bcd_display #(.NUM_DIGITS(4), .TICK_DIV(4), .START_BCD(32'h0000_0907),
        .PENALTY(10), .SCAN_BITS(3), .DP_POS(1)) disp_a (
        .clock(clock), .reset(reset), .start(1'b0), .pause(1'b0), .load(1'b0), .miss(1'b0),
        .seg(seg_a), .dp(dp_a), .an(an_a), .time_bcd(t_a), .running(r_a), .expired(e_a),
        .expire_pulse(p_a));

    countdown_bcd_display #(.NUM_DIGITS(4), .TICK_DIV(4), .START_BCD(32'h0000_F0B7),
        .PENALTY(10), .SCAN_BITS(3), .DP_POS(1)) disp_b (
        .clock(clock), .reset(reset), .start(1'b0), .pause(1'b0), .load(1'b0), .miss(1'b0),
        .seg(seg_b), .dp(dp_b), .an(an_b), .time_bcd(t_b), .running(r_b), .expired(e_b),
        .expire_pulse(p_b));

    countdown_bcd_display #(.NUM_DIGITS(4), .TICK_DIV(4), .START_BCD(32'h0000_0007),
        .PENALTY(10), .SCAN_BITS(3), .DP_POS(1)) disp_c (
        .clock(clock), .reset(reset), .start(1'b0), .pause(1'b0), .load(1'b0), .miss(1'b0),
        .seg(seg_c), .dp(dp_c), .an(an_c), .time_bcd(t_c), .running(r_c), .expired(e_c),
        .expire_pulse(p_c));

    // Scan slot the displays should be on: counts edges since reset release.
    logic [2:0] slot;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) slot <= 3'd0;
        else        slot <= slot + 3'd1;
    end

    typedef struct {
        logic        st, pa, ld, ms;
        int          n;
        logic [15:0] t;
        logic        r, e, p;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, pa, ld, ms, input int n, input logic [15:0] t,
                       input logic r, e, p);
        vec_t v;
        v.st = st; v.pa = pa; v.ld = ld; v.ms = ms; v.n = n;
        v.t = t; v.r = r; v.e = e; v.p = p;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // {an[3:0], seg[6:0], dp} per scan slot
    logic [11:0] exp_a[8], exp_b[8], exp_c[8];

    initial begin
        exp_a[0] = {4'b1110, 7'b1111000, 1'b0};
        exp_a[1] = {4'b1101, 7'b1000000, 1'b1};
        exp_a[2] = {4'b1011, 7'b0010000, 1'b0};
        exp_b[0] = {4'b1110, 7'b1111000, 1'b0};
        exp_b[1] = {4'b1101, 7'b0111111, 1'b1};
        exp_b[2] = {4'b1011, 7'b1000000, 1'b0};
        exp_b[3] = {4'b0111, 7'b0111111, 1'b0};
        exp_c[0] = {4'b1110, 7'b1111000, 1'b0};
        exp_c[1] = {4'b1101, 7'b1000000, 1'b1};
`ifdef LEADING_ZERO_BLANK_EN
        exp_a[3] = {4'b1111, 7'b1000000, 1'b0};
        exp_c[2] = {4'b1111, 7'b1000000, 1'b0};
        exp_c[3] = {4'b1111, 7'b1000000, 1'b0};
`else
        exp_a[3] = {4'b0111, 7'b1000000, 1'b0};
        exp_c[2] = {4'b1011, 7'b1000000, 1'b0};
        exp_c[3] = {4'b0111, 7'b1000000, 1'b0};
`endif
        for (int i = 4; i < 8; i++) begin
            exp_a[i] = {4'b1111, 7'b1111111, 1'b0};
            exp_b[i] = {4'b1111, 7'b1111111, 1'b0};
            exp_c[i] = {4'b1111, 7'b1111111, 1'b0};
        end

        //   st pa ld ms  n   time     r  e  p
        add(1, 0, 0, 0,  1, 16'h0050, 1, 0, 0);
        add(0, 0, 0, 0,  3, 16'h0050, 1, 0, 0);
        add(0, 0, 0, 0,  1, 16'h0049, 1, 0, 0);  // first tick, borrow 50->49
        add(0, 0, 0, 1,  1, 16'h0049, 1, 0, 0);  // pend=10
        add(0, 0, 0, 0,  1, 16'h0048, 1, 0, 0);  // drain, pend=9
        add(0, 0, 0, 1,  1, 16'h0047, 1, 0, 0);  // miss+drain, pend=18
        add(0, 0, 0, 0,  1, 16'h0046, 1, 0, 0);  // tick, pend stays 18
        add(0, 0, 0, 0, 24, 16'h0022, 1, 0, 0);  // 18 drains + 6 ticks
        add(0, 0, 0, 0,  3, 16'h0022, 1, 0, 0);  // queue empty, only ticks
        add(0, 0, 0, 0,  1, 16'h0021, 1, 0, 0);
        add(0, 0, 0, 0,  1, 16'h0021, 1, 0, 0);  // prescaler 1
        add(0, 1, 0, 0,  1, 16'h0021, 0, 0, 0);  // pause, prescaler holds 2
        add(0, 0, 0, 0, 20, 16'h0021, 0, 0, 0);
        add(1, 0, 0, 0,  1, 16'h0021, 1, 0, 0);
        add(0, 0, 0, 0,  1, 16'h0021, 1, 0, 0);
        add(0, 0, 0, 0,  1, 16'h0020, 1, 0, 0);  // tick one cycle after resume
        add(0, 1, 0, 0,  1, 16'h0020, 0, 0, 0);
        add(0, 0, 0, 1,  1, 16'h0020, 0, 0, 0);  // miss queued in pause
        add(0, 0, 0, 0,  3, 16'h0020, 0, 0, 0);
        add(1, 0, 0, 0,  1, 16'h0020, 1, 0, 0);
        add(0, 0, 0, 0, 13, 16'h0007, 1, 0, 0);  // 10 drains + 3 ticks
        add(0, 0, 0, 0,  1, 16'h0007, 1, 0, 0);
        add(0, 0, 0, 0,  1, 16'h0006, 1, 0, 0);
        add(0, 0, 0, 0,  3, 16'h0006, 1, 0, 0);
        add(0, 0, 0, 0,  1, 16'h0005, 1, 0, 0);
        add(0, 0, 0, 1,  1, 16'h0005, 1, 0, 0);  // miss at 5
        add(0, 0, 0, 0,  5, 16'h0000, 1, 0, 0);
        add(0, 0, 0, 0,  1, 16'h0000, 0, 1, 1);  // expiry entry
        add(0, 0, 0, 0,  1, 16'h0000, 0, 1, 0);  // pulse lasts one cycle
        add(0, 0, 0, 0,  9, 16'h0000, 0, 1, 0);  // no wrap to 9999
        add(1, 0, 0, 0,  1, 16'h0000, 0, 1, 0);
        add(0, 0, 0, 1,  1, 16'h0000, 0, 1, 0);
        add(0, 1, 0, 0,  1, 16'h0000, 0, 1, 0);
        add(1, 0, 1, 1,  1, 16'h0050, 0, 0, 0);  // load wins
        add(0, 0, 0, 0,  6, 16'h0050, 0, 0, 0);
        add(0, 0, 0, 1,  1, 16'h0050, 0, 0, 0);  // miss ignored in idle
        add(1, 0, 0, 0,  1, 16'h0050, 1, 0, 0);
        add(0, 0, 0, 0,  3, 16'h0050, 1, 0, 0);
        add(0, 0, 0, 0,  1, 16'h0049, 1, 0, 0);
        add(0, 1, 1, 1,  1, 16'h0050, 0, 0, 0);  // load in run
        add(0, 0, 0, 0,  4, 16'h0050, 0, 0, 0);

        // reset state
        #12;
        chk("reset main", {13'd0, t_m, r_m, e_m, p_m}, {13'd0, 16'h0050, 3'b000});
        chk("reset main disp", {20'd0, an_m, seg_m, dp_m}, {20'd0, 4'b1110, 7'b1000000, 1'b0});
        chk("reset a", {13'd0, t_a, r_a, e_a, p_a}, {13'd0, 16'h0907, 3'b000});
        chk("reset b", {13'd0, t_b, r_b, e_b, p_b}, {13'd0, 16'hF0B7, 3'b000});
        chk("reset c", {13'd0, t_c, r_c, e_c, p_c}, {13'd0, 16'h0007, 3'b000});
        @(negedge clock);
        reset = 1'b1;
        step();

        foreach (vecs[i]) begin
            start = vecs[i].st; pause = vecs[i].pa; load = vecs[i].ld; miss = vecs[i].ms;
            step();
            start = 1'b0; pause = 1'b0; load = 1'b0; miss = 1'b0;
            for (int k = 1; k < vecs[i].n; k++) step();
            chk($sformatf("row%0d", i), {13'd0, t_m, r_m, e_m, p_m},
                {13'd0, vecs[i].t, vecs[i].r, vecs[i].e, vecs[i].p});
        end

        // display scan over all eight slots
        for (int k = 0; k < 8; k++) begin
            logic [11:0] ga, gb, gc, xa, xb, xc;
            step();
            ga = {an_a, seg_a, dp_a}; xa = exp_a[slot];
            gb = {an_b, seg_b, dp_b}; xb = exp_b[slot];
            gc = {an_c, seg_c, dp_c}; xc = exp_c[slot];
            if (slot >= 3'd4) begin
                ga[7:1] = 7'd0; xa[7:1] = 7'd0;
                gb[7:1] = 7'd0; xb[7:1] = 7'd0;
                gc[7:1] = 7'd0; xc[7:1] = 7'd0;
            end
            chk($sformatf("disp a slot%0d", slot), {20'd0, ga}, {20'd0, xa});
            chk($sformatf("disp b slot%0d", slot), {20'd0, gb}, {20'd0, xb});
            chk($sformatf("disp c slot%0d", slot), {20'd0, gc}, {20'd0, xc});
        end

        // asynchronous reset in the middle of a run
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("pre-reset run", {13'd0, t_m, r_m, e_m, p_m}, {13'd0, 16'h0049, 3'b100});
        #2 reset = 1'b0;
        #1;
        chk("async reset", {13'd0, t_m, r_m, e_m, p_m}, {13'd0, 16'h0050, 3'b000});
        chk("async reset an", {28'd0, an_m}, {28'd0, 4'b1110});
        @(negedge clock);
        reset = 1'b1;
        repeat (6) step();
        chk("post-reset idle", {13'd0, t_m, r_m, e_m, p_m}, {13'd0, 16'h0050, 3'b000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_bcd_display.md
Name: countdown_bcd_display

Overview:
- Parametrised countdown game timer with an integrated multiplexed 7-segment driver.
- Remaining time is held directly as a BCD digit chain, so display extraction needs no divide or modulo.
- A sequenced controller handles start/pause/load, miss penalties and expiry.
- Sits between game control logic (`start`, `miss`, `load`) and the board's 7-segment/anode pins.

Parameters:
- `NUM_DIGITS`, 8, number of BCD digits and anodes (2..8).
- `TICK_DIV`, 5000, clock cycles per countdown tick (≥ 4).
- `START_BCD`, 32'h0018_0000, reload value: packed BCD, digit 0 in bits [3:0]; only the low 4*`NUM_DIGITS` bits are used.
- `PENALTY`, 10, ticks removed per `miss` pulse (1..255).
- `SCAN_BITS`, 6, refresh counter width; digit select = `refresh[SCAN_BITS-1:SCAN_BITS-3]`.
- `DP_POS`, 4, digit index whose decimal point is lit.

Ports:
- `clock`, in, 1, system clock.
- `reset`, in, 1, asynchronous active-low reset.
- `start`, in, 1, single-cycle pulse: IDLE→RUN, or PAUSE→RUN.
- `pause`, in, 1, single-cycle pulse: RUN→PAUSE.
- `load`, in, 1, single-cycle pulse: reload `START_BCD`, go to IDLE.
- `miss`, in, 1, single-cycle pulse: queue `PENALTY` decrements.
- `seg`, out, 7, active-low segments {g,f,e,d,c,b,a}.
- `dp`, out, 1, decimal point, active-high as driven.
- `an`, out, `NUM_DIGITS`, active-low anode select.
- `time_bcd`, out, 4*`NUM_DIGITS`, live remaining time in BCD.
- `running`, out, 1, high in RUN.
- `expired`, out, 1, high in EXPIRED (game fail).
- `expire_pulse`, out, 1, one-cycle strobe on entry to EXPIRED.

Behaviour:
- **Reset** (`reset`=0, asynchronous):
  - state=IDLE; `time_bcd`=`START_BCD`; prescaler=0; `pend`=0; refresh=0.
  - `running`=0, `expired`=0, `expire_pulse`=0.
  - `an`=digit-0 select; `seg` shows digit 0 of `START_BCD`.
- **States:** IDLE, RUN, PAUSE, EXPIRED.
  - IDLE: `start`→RUN.
  - RUN: `pause`→PAUSE; count reaching zero→EXPIRED.
  - PAUSE: `start`→RUN.
  - EXPIRED: only `load` exits.
  - `load` in any state→IDLE with full reload and `pend`=0; `load` has priority over all other inputs in the same cycle.
- **Prescaler:**
  - Counts 0..`TICK_DIV`-1 only in RUN; holds its value in PAUSE; clears in IDLE/EXPIRED.
  - `tick`=1 on the cycle it equals `TICK_DIV`-1, then it wraps to 0.
- **Decrement engine:** at most one BCD decrement per cycle.
  - Digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
  - Source priority: `tick` first; otherwise one pending penalty step if `pend`>0 (then `pend`-1).
- **Penalty queue:**
  - `miss` adds `PENALTY` to `pend`, an 8-bit register saturating at 255.
  - Accepted only in RUN and PAUSE; ignored in IDLE and EXPIRED.
  - Pending steps drain only in RUN. `miss` and a drain in the same cycle net to `pend`+`PENALTY`-1.
- **Zero boundary:**
  - A decrement applied to value 1 yields 0; the next cycle enters EXPIRED, `pend` clears and `expire_pulse`=1 for exactly one cycle.
  - Decrement is never applied at 0, so there is no wrap to all-9s.
- **`time_bcd`:** updates on the same edge as the decrement, with zero latency from `tick`.
- **Display:**
  - refresh free-runs in every state.
  - Digit index i = top 3 bits; if i ≥ `NUM_DIGITS`, all anodes are off (all 1).
  - `an[i]`=0; `seg`=decode(digit i); `dp`=1 when i=`DP_POS`.
  - Decode 0..9 standard active-low (0→7'b1000000, 8→7'b0000000); codes A–F decode to dash 7'b0111111.
  - `seg`/`an`/`dp` are combinational from refresh and `time_bcd`.

Optional Feature:
- Macro `LEADING_ZERO_BLANK_EN`.
- **Defined:** while digit i is 0 and all digits above it are 0, `an` is forced all-1 for that slot. Digit 0 and digits ≤ `DP_POS` are never blanked.
- **Undefined:** all digits are always displayed.

Test Plan:
- Reset, then pulse `start` with `TICK_DIV`=4, `START_BCD`=16'h0012, `NUM_DIGITS`=4 → `time_bcd` steps 0012→0011→0010→0009 every 4 cycles; `running`=1.
- Run down to 0001 → after one more tick `time_bcd`=0000, next cycle `expired`=1, `expire_pulse` high exactly 1 cycle, no further decrements.
- `miss` at value 0025 with `PENALTY`=10 and ticks also running → value reaches 0015 minus elapsed ticks. `miss`+drain in one cycle gives the correct `pend`. `miss` at 0005 → expires at 0000, with no wrap to 9999.
- `pause` mid-prescale at count 2, wait 20 cycles, `start` → first tick after 1 more cycle; `time_bcd` unchanged during PAUSE; `miss` in PAUSE is queued and drains after resume.
- `load` in EXPIRED and asserted together with `start`/`miss` → IDLE, `time_bcd`=`START_BCD`, `pend`=0, `expired`=0. Assert `reset`=0 mid-run → immediate reload and IDLE.
- Display: with `time_bcd`=16'h0907 step refresh → `an` 1110/1101/1011/0111 with `seg` 1111000/1000000/0010000/1000000. Codes ≥ A show a dash. With `LEADING_ZERO_BLANK_EN` defined and `DP_POS`=1, value 0007 → digits 3 and 2 blank.
